// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU matrix pipeline (loader and determinant stage).
// Fixes the packed 5x5 matrix layout so that every stage agrees on where
// element (row,col) lives: bits at(row,col) +: ELEM_W, unused positions zero.
package mpu_pkg;

    localparam int MPU_DIM      = 5;
    localparam int ELEM_W       = 8;
    localparam int MAT_W        = ELEM_W * MPU_DIM * MPU_DIM;
    localparam int MPU_SIZE_MIN = 2;
    localparam int MPU_SIZE_MAX = 5;
    // Width of a row/column index (0..MPU_DIM-1).
    localparam int RC_W         = $clog2(MPU_DIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } mpu_state_e;

    // Bit offset of element (row,col) inside the packed matrix.
    function automatic int unsigned at(input logic [RC_W-1:0] row,
                                       input logic [RC_W-1:0] col);
        return ELEM_W * (int'(col) + MPU_DIM * int'(row));
    endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row/column counter for a row-major walk over an N x N matrix.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   clear_i       - restart the walk at (0,0)
//   advance_i     - step to the next element (col wraps at N-1, row increments)
//   size_i        - N, the current matrix dimension
//   row_o, col_o  - current position
//   last_o        - current position is (N-1,N-1)
module mpu_rc_counter
    import mpu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            advance_i,
    input  logic [RC_W-1:0] size_i,
    output logic [RC_W-1:0] row_o,
    output logic [RC_W-1:0] col_o,
    output logic            last_o
);

    logic [RC_W-1:0] row_q, row_d;
    logic [RC_W-1:0] col_q, col_d;
    logic [RC_W-1:0] size_m1;

    assign size_m1 = size_i - RC_W'(1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (col_q == size_m1) begin
                col_d = '0;
                row_d = row_q + RC_W'(1);
            end else begin
                col_d = col_q + RC_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == size_m1) && (col_q == size_m1);

endmodule

// File: rtl/mpu_matrix_loader.sv
// Front end of the MPU determinant unit. Takes a start command with size N
// (2..5), collects N*N signed elements in row-major order over valid/ready,
// and presents them in the shared packed 5x5 layout until acknowledged.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   start          - command strobe, only looked at in IDLE
//   start_size     - requested N; values outside 2..5 raise error
//   in_data        - element stream, in_valid/in_ready handshake
//   matrix, size   - assembled matrix and its N, stable while matrix_valid
//   matrix_valid   - matrix complete; cleared by matrix_ack
//   busy           - loader is in LOAD or HOLD
//   error          - sticky, set by an illegal start, cleared by a legal one
module mpu_matrix_loader
    import mpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        start_size,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [MAT_W-1:0]  matrix,
    output logic [7:0]        size,
    output logic              matrix_valid,
    input  logic              matrix_ack,
    output logic              busy,
    output logic              error
);

    mpu_state_e       state_q, state_d;
    logic [MAT_W-1:0] matrix_q, matrix_d;
    logic [7:0]       size_q;
    logic             valid_q;
    logic             error_q;

    logic             start_ok;
    logic             start_bad;
    logic             xfer;
    logic             ack_take;
    logic             size_legal;

    logic [RC_W-1:0]  row, col;
    logic             last;

    assign size_legal = (start_size >= 8'(MPU_SIZE_MIN)) &&
                        (start_size <= 8'(MPU_SIZE_MAX));

    mpu_rc_counter u_rc (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (start_ok),
        .advance_i (xfer),
        .size_i    (size_q[RC_W-1:0]),
        .row_o     (row),
        .col_o     (col),
        .last_o    (last)
    );

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        xfer      = 1'b0;
        ack_take  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_legal) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                xfer = in_valid;
                if (in_valid && last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // An ack takes priority; a coincident start is dropped and
                // only seen again if still asserted once back in IDLE.
                if (matrix_ack) begin
                    ack_take = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A legal start wipes the whole matrix so positions outside N x N read
    // as zero padding for the determinant stage.
    always_comb begin
        matrix_d = matrix_q;
        if (start_ok) begin
            matrix_d = '0;
        end else if (xfer) begin
            matrix_d[at(row, col) +: ELEM_W] = in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            matrix_q <= '0;
            size_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            matrix_q <= matrix_d;
            if (start_ok) begin
                size_q  <= start_size;
                error_q <= 1'b0;
            end
            if (start_bad) begin
                error_q <= 1'b1;
            end
            if (xfer && last) begin
                valid_q <= 1'b1;
            end
            if (ack_take) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign matrix       = matrix_q;
    assign size         = size_q;
    assign matrix_valid = valid_q;
    assign error        = error_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
module tb_mpu_matrix_loader;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   start_size;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] matrix;
    logic [7:0]   size;
    logic         matrix_valid;
    logic         matrix_ack;
    logic         busy;
    logic         error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int                 n;
        bit                 gap;
        logic [24:0][7:0]   el;
        logic [199:0]       exp_mat;
    } vec_t;

    vec_t         vecs [4];
    logic [199:0] exp_q [$];
    int           size_q [$];

    always #5 clock = ~clock;

    mpu_matrix_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_size   (start_size),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .matrix       (matrix),
        .size         (size),
        .matrix_valid (matrix_valid),
        .matrix_ack   (matrix_ack),
        .busy         (busy),
        .error        (error)
    );

    // Reference packing: element (r,c) of an n x n row-major stream at byte c+5r.
    function automatic logic [199:0] build(input int n, input logic [24:0][7:0] el);
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                m[8*(c+5*r) +: 8] = el[r*n+c];
        return m;
    endfunction

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs start + full stream for vector v; leaves the DUT in HOLD.
    task automatic load(input int v);
        int i;
        int k;
        bit vld;
        exp_q.push_back(vecs[v].exp_mat);
        size_q.push_back(vecs[v].n);
        start = 1'b1;
        start_size = 8'(vecs[v].n);
        @(negedge clock);
        start = 1'b0;
        chk("start_busy", 200'(busy), 200'(1));
        chk("start_error_clear", 200'(error), 200'(0));
        i = 0;
        k = 0;
        while (i < vecs[v].n * vecs[v].n && k < 200) begin
            chk("in_ready_load", 200'(in_ready), 200'(1));
            vld = !(vecs[v].gap && (k % 3 == 2));
            in_valid = vld;
            in_data = vecs[v].el[i];
            @(negedge clock);
            k++;
            if (vld) i++;
        end
        in_valid = 1'b0;
        if (k >= 200) begin
            errors++;
            $display("FAIL load_timeout: got %0d transfers expected %0d", i, vecs[v].n * vecs[v].n);
        end
        chk("valid_latency", 200'(matrix_valid), 200'(1));
        chk("in_ready_hold", 200'(in_ready), 200'(0));
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            chk("matrix", matrix, exp_q.pop_front());
            chk("size", 200'(size), 200'(size_q.pop_front()));
        end
        $display("load vec=%0d n=%0d cycles=%0d matrix=%h", v, vecs[v].n, k, matrix);
    endtask

    task automatic ack(input logic [199:0] exp_mat, input int n);
        matrix_ack = 1'b1;
        @(negedge clock);
        matrix_ack = 1'b0;
        chk("ack_valid_clear", 200'(matrix_valid), 200'(0));
        chk("ack_busy", 200'(busy), 200'(0));
        chk("ack_matrix_kept", matrix, exp_mat);
        chk("ack_size_kept", 200'(size), 200'(n));
        $display("ack n=%0d", n);
    endtask

    initial begin
        logic [199:0] hand;

        // Table of vectors
        vecs[0].n = 2; vecs[0].gap = 1'b0; vecs[0].el = '0;
        for (int i = 0; i < 4; i++) vecs[0].el[i] = 8'(i + 1);
        vecs[1].n = 5; vecs[1].gap = 1'b1; vecs[1].el = '0;
        for (int i = 0; i < 25; i++) vecs[1].el[i] = 8'(i + 1);
        vecs[2].n = 3; vecs[2].gap = 1'b0; vecs[2].el = '0;
        for (int i = 0; i < 9; i++) vecs[2].el[i] = 8'(i * 7 + 3);
        vecs[2].el[0] = 8'h80;
        vecs[2].el[8] = 8'h7F;
        vecs[2].el[4] = 8'hFF;
        vecs[3].n = 4; vecs[3].gap = 1'b0; vecs[3].el = '0;
        for (int i = 0; i < 16; i++) vecs[3].el[i] = 8'($urandom_range(0, 255));
        for (int v = 0; v < 4; v++) vecs[v].exp_mat = build(vecs[v].n, vecs[v].el);

        reset = 1'b1; start = 1'b0; start_size = '0; in_data = '0;
        in_valid = 1'b0; matrix_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_matrix", matrix, '0);
        chk("rst_size", 200'(size), 200'(0));
        chk("rst_valid", 200'(matrix_valid), 200'(0));
        chk("rst_error", 200'(error), 200'(0));
        chk("rst_busy", 200'(busy), 200'(0));
        chk("rst_in_ready", 200'(in_ready), 200'(0));
        reset = 1'b0;
        @(negedge clock);

        // 2x2 back-to-back, with a hand-written layout check
        load(0);
        hand = '0;
        hand[7:0] = 8'd1; hand[15:8] = 8'd2; hand[47:40] = 8'd3; hand[55:48] = 8'd4;
        chk("layout_2x2", matrix, hand);
        ack(vecs[0].exp_mat, 2);

        // 5x5 with gaps, held 10 cycles before ack
        load(1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_valid", 200'(matrix_valid), 200'(1));
            chk("hold_matrix", matrix, vecs[1].exp_mat);
        end
        ack(vecs[1].exp_mat, 5);

        // Illegal size then a legal 3x3 with extreme values
        start = 1'b1; start_size = 8'd6;
        @(negedge clock);
        start = 1'b0;
        chk("bad_error", 200'(error), 200'(1));
        chk("bad_busy", 200'(busy), 200'(0));
        chk("bad_in_ready", 200'(in_ready), 200'(0));
        chk("bad_size_kept", 200'(size), 200'(5));
        chk("bad_matrix_kept", matrix, vecs[1].exp_mat);
        $display("bad start size=6 error=%0d", error);
        load(2);
        ack(vecs[2].exp_mat, 3);

        // Reset in the middle of a 4x4 load
        start = 1'b1; start_size = 8'd4;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = vecs[3].el[i];
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_matrix", matrix, '0);
        chk("midrst_busy", 200'(busy), 200'(0));
        chk("midrst_valid", 200'(matrix_valid), 200'(0));
        chk("midrst_size", 200'(size), 200'(0));
        $display("reset after 7 of 16 elements");
        load(0);
        ack(vecs[0].exp_mat, 2);

        // Full 4x4 random, then start coincident with ack in HOLD
        load(3);
        matrix_ack = 1'b1; start = 1'b1; start_size = 8'd3;
        @(negedge clock);
        matrix_ack = 1'b0;
        chk("ackstart_busy", 200'(busy), 200'(0));
        chk("ackstart_valid", 200'(matrix_valid), 200'(0));
        chk("ackstart_no_reload", matrix, vecs[3].exp_mat);
        chk("ackstart_size", 200'(size), 200'(4));
        @(negedge clock);
        start = 1'b0;
        chk("restart_busy", 200'(busy), 200'(1));
        chk("restart_in_ready", 200'(in_ready), 200'(1));
        chk("restart_size", 200'(size), 200'(3));
        chk("restart_cleared", matrix, '0);
        $display("ack+start in HOLD, restart size=%0d", size);

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
- Upstream stage of the MPU determinant unit.
- Accepts a start command carrying a matrix size N (2..5), then an N*N stream of signed int8 elements in row-major order over a valid/ready handshake.
- Assembles the elements into the packed 5x5 matrix format consumed by the determinant stage: element (r,c) at bits 8*(c+5*r) +: 8, unused positions zero.
- Presents the matrix and size, held stable, until the consumer acknowledges.

Parameters:
- DIM, 5, maximum matrix dimension; fixes the packed stride at 5 elements per row.
- ELEM_W, 8, element width in bits (signed two's complement).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- start_size  input  8  requested N; legal values are 2..5.
- in_data  input  8  signed element, row-major order.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- matrix  output  200  packed 5x5 matrix; element (r,c) at 8*(c+5*r) +: 8.
- size  output  8  latched N for the held matrix.
- matrix_valid  output  1  matrix/size complete and stable.
- matrix_ack  input  1  consumer has taken the matrix.
- busy  output  1  high in LOAD or HOLD.
- error  output  1  sticky flag for an illegal start_size.

Behaviour:
- Reset (synchronous, active-high, overrides all other activity):
  - state is IDLE.
  - matrix, size and the row/col counters are 0.
  - matrix_valid=0, error=0.
  - in_ready and busy are 0, as decoded from IDLE.
- States are IDLE, LOAD and HOLD.
- Decoded outputs: in_ready = (state==LOAD) and busy = (state!=IDLE). Both are combinational from state only; in_ready does not depend on in_valid.
- IDLE with start=1:
  - If start_size is in 2..5: latch size, clear all 200 matrix bits to 0, set row=col=0, error<=0, go to LOAD.
  - Otherwise: error<=1 and remain in IDLE; size and matrix are unchanged.
- error stays set until the next legal start or reset.
- LOAD, transfer rules:
  - A transfer occurs when in_valid && in_ready.
  - Each transfer writes in_data to (row,col).
  - If col==N-1: col<=0 and row<=row+1. Otherwise col<=col+1.
  - No transfer means no state change, so gaps in in_valid are allowed.
- LOAD, last element (transfer at row==N-1, col==N-1):
  - On the same edge: state<=HOLD and matrix_valid<=1.
  - matrix_valid is therefore high in the cycle after the last handshake. in_ready drops in that cycle.
- Total LOAD occupancy is exactly N*N handshakes.
- HOLD:
  - matrix, size and matrix_valid are stable.
  - On matrix_ack: matrix_valid<=0 and state<=IDLE. matrix and size keep their values until the next legal start.
- start in LOAD or HOLD is ignored, with no error.
- Simultaneous start and matrix_ack in HOLD: the ack is taken and start is ignored. A start still asserted on the next cycle is honoured from IDLE.
- matrix_ack outside HOLD is ignored.
- in_valid outside LOAD: no transfer; data is dropped by the source's own rule.
- Reset during LOAD or HOLD discards the partial or held matrix; all values return to their reset values.
- Elements are stored bit-exact with no arithmetic. Positions with row>=N or col>=N stay zero, giving zero padding for the downstream stage.

Decomposition:
- Shared package mpu_pkg holds:
  - MPU_DIM=5, ELEM_W=8, MAT_W=ELEM_W*MPU_DIM*MPU_DIM=200.
  - MPU_SIZE_MIN=2, MPU_SIZE_MAX=5.
  - The element offset function at(row,col)=ELEM_W*(col+MPU_DIM*row).
  - The state encoding enum {IDLE, LOAD, HOLD}.
- The determinant stage uses the same package, so both stages share one packed layout.
- One natural sub-module: mpu_rc_counter, a row/col counter with size-bounded wrap and a last flag. Everything else stays in the top module.

Test Plan:
- start, start_size=2, stream 1,2,3,4 back-to-back:
  - matrix_valid rises 1 cycle after the 4th handshake.
  - Bytes at offsets 0,1,5,6 are 1,2,3,4; all other bytes are 0; size=2.
- start_size=5, stream 1..25 with in_valid deasserted on every third cycle:
  - Element (r,c) = 5r+c+1.
  - in_ready stays high until the 25th transfer.
  - matrix_valid holds across 10 cycles without ack; ack clears it next cycle.
- start_size=6 in IDLE: error=1, state stays IDLE, in_ready=0. A following start_size=3 clears error and enters LOAD.
- Reset asserted after 7 of 16 elements of a 4x4 load: next cycle matrix=0, busy=0, matrix_valid=0. A new 2x2 load then completes correctly.
- In HOLD, assert start(size=3) together with matrix_ack: return to IDLE with no reload. Start held one more cycle enters LOAD with size=3 and the matrix cleared.
- Elements -128 and 127 in a 3x3 load: bytes 0x80 and 0x7F stored unchanged at the correct offsets.
